// File: rtl/piece_queue_if.sv
// Handshake bundle between the piece generator / game FSM and piece_queue_ctrl.
// The master side drives the generator samples and pops; the slave side is the queue.
interface piece_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          gen_ready;
  logic [2:0]    gen_piece;
  logic          pop;
  logic          piece_valid;
  logic [2:0]    piece_out;
  logic          next_valid;
  logic [2:0]    next_piece;
  logic [CW-1:0] count;
  logic          underflow;

  modport master (
    output gen_ready, gen_piece, pop,
    input  piece_valid, piece_out, next_valid, next_piece, count, underflow
  );

  modport slave (
    input  gen_ready, gen_piece, pop,
    output piece_valid, piece_out, next_valid, next_piece, count, underflow
  );
endinterface

// File: rtl/piece_queue_ctrl.sv
// Warm-up filter plus DEPTH-entry preview FIFO between the piece generator and game FSM.
// Optional 7-bag dealing is enabled by defining PIECE_BAG_EN.
module piece_queue_ctrl #(
  parameter int DEPTH  = 4,
  parameter int WARMUP = 16
) (
  input  logic         clk,
  input  logic         nreset,
  piece_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  localparam logic [1:0] S_WARMUP = 2'd0;
  localparam logic [1:0] S_FILL   = 2'd1;
  localparam logic [1:0] S_SERVE  = 2'd2;

  logic [1:0]             state;
  logic [WW-1:0]          warm;
  logic [PW-1:0]          rd_ptr, wr_ptr, rd_ptr_n1;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [DEPTH-1:0][2:0]  mem;
  logic                   underflow_q;
  logic                   active, pop_eff, push, bag_ok;

`ifdef PIECE_BAG_EN
  logic [6:0] bag_used, bag_set, bag_nxt;
  logic [7:0] bag_ext;

  // Code 7 maps onto the forced-set top bit, so the index never leaves the vector.
  always_comb begin
    bag_ext = {1'b1, bag_used};
    bag_ok  = !bag_ext[bus.gen_piece];
    bag_set = bag_used | (7'd1 << bus.gen_piece);
    bag_nxt = (&bag_set) ? 7'd0 : bag_set;
  end

  always_ff @(posedge clk) begin
    if (!nreset)   bag_used <= 7'd0;
    else if (push) bag_used <= bag_nxt;
  end
`else
  assign bag_ok = 1'b1;
`endif

  always_comb begin
    active  = (state != S_WARMUP);
    pop_eff = active && bus.pop && (cnt != '0);
    // A full FIFO still accepts when the head leaves on the same edge.
    push    = active && bus.gen_ready && (bus.gen_piece != 3'b111) && bag_ok &&
              ((cnt < CW'(DEPTH)) || pop_eff);
    cnt_nxt = cnt + CW'(push) - CW'(pop_eff);
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state       <= S_WARMUP;
      warm        <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      cnt         <= '0;
      underflow_q <= 1'b0;
    end else begin
      case (state)
        S_WARMUP: begin
          underflow_q <= bus.pop;
          if (warm == WW'(WARMUP - 1)) state <= S_FILL;
          else                         warm  <= warm + 1'b1;
        end
        default: begin
          underflow_q <= bus.pop && (cnt == '0);
          if (pop_eff) rd_ptr <= rd_ptr + 1'b1;
          if (push)    wr_ptr <= wr_ptr + 1'b1;
          cnt   <= cnt_nxt;
          state <= (cnt_nxt == CW'(DEPTH)) ? S_SERVE : S_FILL;
        end
      endcase
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.gen_piece;
  end

  assign rd_ptr_n1       = rd_ptr + 1'b1;
  assign bus.piece_valid = (cnt != '0);
  assign bus.piece_out   = bus.piece_valid ? mem[rd_ptr] : 3'b000;
  assign bus.next_valid  = (cnt >= CW'(2));
  assign bus.next_piece  = bus.next_valid ? mem[rd_ptr_n1] : 3'b000;
  assign bus.count       = cnt;
  assign bus.underflow   = underflow_q;
endmodule

// File: tb/tb_piece_queue_ctrl.sv
// Randomized scoreboard bench for piece_queue_ctrl against a queue-based reference model.
module tb_piece_queue_ctrl;
  localparam int DEPTH  = 4;
  localparam int WARMUP = 16;

  typedef struct {
    bit       pv;
    bit [2:0] po;
    bit       nv;
    bit [2:0] np;
    int       cnt;
    bit       uf;
  } exp_t;

  logic clk = 1'b0;
  logic nreset;
  int   checks = 0;
  int   failures = 0;
  bit   done = 1'b0;

  piece_queue_if #(.DEPTH(DEPTH)) bus ();
  piece_queue_ctrl #(.DEPTH(DEPTH), .WARMUP(WARMUP)) dut (.clk(clk), .nreset(nreset), .bus(bus));

  always #5 clk = ~clk;

  // Reference model: a plain queue of pieces plus warm-up and bag bookkeeping.
  bit [2:0] m_q[$];
  int       m_warm_left;
  bit       m_uf;
  bit [6:0] m_bag;
  exp_t     exp_q[$];

  task automatic step(input bit rn, input bit gr, input bit [2:0] gp, input bit pp);
    exp_t e;
    bit   popeff, accept;
    nreset        = rn;
    bus.gen_ready = gr;
    bus.gen_piece = gp;
    bus.pop       = pp;
    if (!rn) begin
      m_q.delete();
      m_warm_left = WARMUP;
      m_uf        = 1'b0;
      m_bag       = 7'd0;
    end else if (m_warm_left > 0) begin
      m_uf = pp;
      m_warm_left--;
    end else begin
      popeff = pp && (m_q.size() > 0);
      m_uf   = pp && (m_q.size() == 0);
      accept = gr && (gp != 3'd7) && ((m_q.size() < DEPTH) || popeff);
`ifdef PIECE_BAG_EN
      if (accept && m_bag[gp]) accept = 1'b0;
`endif
      if (popeff) void'(m_q.pop_front());
      if (accept) begin
        m_q.push_back(gp);
        m_bag[gp] = 1'b1;
        if (m_bag == 7'h7f) m_bag = 7'd0;
      end
    end
    e.pv  = m_q.size() > 0;
    e.po  = e.pv ? m_q[0] : 3'd0;
    e.nv  = m_q.size() > 1;
    e.np  = e.nv ? m_q[1] : 3'd0;
    e.cnt = m_q.size();
    e.uf  = m_uf;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: every edge the DUT presents a full output snapshot; compare to the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done) break;
      if (exp_q.size() == 0) continue;
      e = exp_q.pop_front();
      checks++;
      if (bus.piece_valid !== e.pv || bus.piece_out !== e.po || bus.next_valid !== e.nv ||
          bus.next_piece !== e.np || int'(bus.count) != e.cnt || bus.underflow !== e.uf) begin
        failures++;
        $display("FAIL outputs t=%0t got pv=%0b po=%0d nv=%0b np=%0d cnt=%0d uf=%0b want pv=%0b po=%0d nv=%0b np=%0d cnt=%0d uf=%0b",
                 $time, bus.piece_valid, bus.piece_out, bus.next_valid, bus.next_piece,
                 bus.count, bus.underflow, e.pv, e.po, e.nv, e.np, e.cnt, e.uf);
      end
    end
  end

  initial begin
    int pop_pct, rdy_pct;
    step(1'b0, 1'b0, 3'd0, 1'b0);
    step(1'b0, 1'b1, 3'd2, 1'b1);
    // Warm-up discard with a held sample, then fill to full.
    for (int i = 0; i < 22; i++) step(1'b1, 1'b1, 3'd2, 1'b0);
    // Restart and build {1,2,3,4}, then pop while pushing 5.
    step(1'b0, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < WARMUP; i++) step(1'b1, 1'b0, 3'd0, (i % 5) == 0);
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 3'(i), 1'b0);
    step(1'b1, 1'b1, 3'd5, 1'b1);
    step(1'b1, 1'b1, 3'd6, 1'b0);
    // Drain past empty to provoke underflow, then an invalid code while filling.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 3'd0, 1'b1);
    step(1'b1, 1'b0, 3'd0, 1'b0);
    step(1'b1, 1'b1, 3'd7, 1'b0);
    step(1'b1, 1'b1, 3'd7, 1'b1);
    // Mid-operation reset at count 3.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 3'(i), 1'b0);
    step(1'b0, 1'b1, 3'd4, 1'b0);
    for (int i = 0; i < WARMUP + 2; i++) step(1'b1, 1'b1, 3'd3, 1'b0);
`ifdef PIECE_BAG_EN
    step(1'b0, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < WARMUP; i++) step(1'b1, 1'b0, 3'd0, 1'b0);
    begin
      bit [2:0] seq[9] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd6};
      foreach (seq[i]) step(1'b1, 1'b1, seq[i], i >= 3);
    end
`endif
    // Random phases with varying pop / ready pressure and rare resets.
    for (int ph = 0; ph < 30; ph++) begin
      pop_pct = $urandom_range(5, 90);
      rdy_pct = $urandom_range(10, 100);
      for (int i = 0; i < 100; i++)
        step($urandom_range(0, 199) != 0, $urandom_range(1, 100) <= rdy_pct,
             3'($urandom_range(0, 7)), $urandom_range(1, 100) <= pop_pct);
    end
    step(1'b1, 1'b0, 3'd0, 1'b0);
    done = 1'b1;
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain leftover=%0d want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
